// File: rtl/payload_deserializer_pkg.sv
// Shared definitions for the payload deserializer and its companion header detector.
package payload_deserializer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StHold  = 2'b10
    } state_e;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultCntW  = 4;

    // Header that precedes every payload; the detector matches it before raising serOutValid.
    localparam logic [5:0] HeaderPattern = 6'b110101;

endpackage

// File: rtl/payload_deserializer_if.sv
// Serial-in / parallel-out bundle between the detector, the deserializer and the word consumer.
interface payload_deserializer_if
    import payload_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = DefaultCntW
) ();

    logic             serIn;
    logic             serInValid;
    logic             word_ack;
    logic [WIDTH-1:0] parOut;
    logic             parValid;
    logic [CNT_W-1:0] lenOut;
    logic             longFrame;
    logic             overrun;

    modport slave (
        input  serIn,
        input  serInValid,
        input  word_ack,
        output parOut,
        output parValid,
        output lenOut,
        output longFrame,
        output overrun
    );

    modport master (
        output serIn,
        output serInValid,
        output word_ack,
        input  parOut,
        input  parValid,
        input  lenOut,
        input  longFrame,
        input  overrun
    );

endinterface

// File: rtl/payload_shift_reg.sv
// MSB-first payload shift register with clear-and-load of the first bit.
module payload_shift_reg
    import payload_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = {{(WIDTH-1){1'b0}}, bit_i};
        end else if (shift_i) begin
            sh_d = {sh_q[WIDTH-2:0], bit_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign data_o = sh_q;

endmodule

// File: rtl/payload_deserializer.sv
// Packs the enabled, valid payload bits into a word and holds it until the consumer acks.
module payload_deserializer
    import payload_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 Clk_EN,
    payload_deserializer_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             long_q, long_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             drop_q, drop_d;
    logic             wait_low_q, wait_low_d;
    logic             wait_set;
    logic             samp;
    logic             sh_load, sh_shift;
    logic [WIDTH-1:0] sh;

    assign samp = Clk_EN & bus.serInValid;

    payload_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .bit_i   (bus.serIn),
        .data_o  (sh)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        len_d     = len_q;
        long_d    = long_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        drop_d    = drop_q;
        wait_set  = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (samp && !wait_low_q) begin
                    sh_load = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!bus.serInValid) begin
                    par_d   = sh;
                    len_d   = cnt_q;
                    long_d  = (32'(cnt_q) > WIDTH);
                    valid_d = 1'b1;
                    state_d = StHold;
                end else if (Clk_EN) begin
                    sh_shift = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (bus.word_ack) begin
                    valid_d = 1'b0;
                    if (drop_q) begin
                        // Tail of the dropped frame may still be on the line.
                        drop_d   = 1'b0;
                        wait_set = 1'b1;
                        state_d  = StIdle;
                    end else if (samp) begin
                        sh_load = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = StShift;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (samp) begin
                    overrun_d = 1'b1;
                    drop_d    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Cleared by any cycle with serInValid low.
        wait_low_d = bus.serInValid & (wait_low_q | wait_set);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            par_q      <= '0;
            len_q      <= '0;
            long_q     <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            drop_q     <= 1'b0;
            wait_low_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            len_q      <= len_d;
            long_q     <= long_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            drop_q     <= drop_d;
            wait_low_q <= wait_low_d;
        end
    end

    assign bus.parOut    = par_q;
    assign bus.lenOut    = len_q;
    assign bus.longFrame = long_q;
    assign bus.parValid  = valid_q;
    assign bus.overrun   = overrun_q;

endmodule
